// File: rtl/param_data_buffer.sv
// -----------------------------------------------------------------------------
// param_data_buffer
//
// Circular byte FIFO between the USB packet engines (byte-wide RX store and
// TX fetch) and the AHB-Lite slave (multi-byte bus read/write). It supports
// configurable depth and bus width, full/empty flags, sticky overflow and
// underflow errors, and a mark/rewind scheme so that a TX packet can be
// retransmitted after a NAK or timeout.
//
// Parameters
//   DEPTH      buffer size in bytes (power of 2, >= 4, >= BUS_BYTES)
//   BUS_BYTES  bus port width in bytes (power of 2, 1..8)
//   RETX_EN    1: explicit mark/rewind, 0: mark follows the read pointer
//
// Ports
//   clk, n_rst            clock (rising edge), async active-low reset
//   clear                 synchronous flush of pointers, outputs and errors
//   store_rx_packet_data  push rx_packet_data (ignored while buffer_reserved)
//   get_rx_data           pop data_size+1 bytes into rx_data
//   store_tx_data         push data_size+1 bytes of tx_data
//   get_tx_packet_data    pop one byte into tx_packet_data
//   mark_set / rewind     release / replay the retransmit region
//   buffer_occupancy      readable bytes; full / empty flags
//   overflow_err          sticky: illegal push seen
//   underflow_err         sticky: illegal pop seen
//
// Request semantics: every request input is a level-sampled strobe. Each
// rising edge on which a request is high performs one transfer; there is no
// ready/back-pressure signal. A request that cannot be honoured is dropped
// and (unless it lost arbitration or was masked) sets a sticky error flag.
// -----------------------------------------------------------------------------
module param_data_buffer #(
  parameter int DEPTH     = 64,
  parameter int BUS_BYTES = 4,
  parameter int RETX_EN   = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   store_rx_packet_data,
  input  logic [7:0]             rx_packet_data,
  input  logic                   get_rx_data,
  input  logic [SW-1:0]          data_size,
  input  logic [8*BUS_BYTES-1:0] tx_data,
  input  logic                   store_tx_data,
  input  logic                   get_tx_packet_data,
  input  logic                   buffer_reserved,
  input  logic                   mark_set,
  input  logic                   rewind,
  output logic [AW:0]            buffer_occupancy,
  output logic [8*BUS_BYTES-1:0] rx_data,
  output logic [7:0]             tx_packet_data,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow_err,
  output logic                   underflow_err
);

  localparam int PW = AW + 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp, rp, mk;
  logic [AW:0] wp_next, rp_next, mk_next;
  logic [AW:0] occ, free_space;

  // Byte address of offset 'off' from pointer 'base', wrapping at DEPTH.
  function automatic logic [AW-1:0] addr_at(input logic [AW:0] base, input int off);
    return AW'(base + PW'(off));
  endfunction

  // Pointers carry one extra wrap bit, so differences are exact modulo 2*DEPTH.
  assign occ        = wp - rp;
  assign free_space = PW'(DEPTH) - (wp - mk);

  assign buffer_occupancy = occ;
  assign full             = (free_space == '0);
  assign empty            = (occ == '0);

  // ---------------------------------------------------------------------------
  // Request arbitration and legality
  // ---------------------------------------------------------------------------
  logic [SW:0] bus_w;
  logic        bus_size_ok;
  logic [AW:0] bus_w_p;

  assign bus_w       = {1'b0, data_size} + (SW+1)'(1);
  assign bus_size_ok = (bus_w <= (SW+1)'(BUS_BYTES));
  assign bus_w_p     = PW'(bus_w);

  logic        rx_push, bus_push, push_req, push_ok, ovf_set;
  logic        tx_pop, bus_pop, pop_req, pop_ok, unf_set;
  logic        do_rewind;
  logic [AW:0] push_w, pop_w;

  always_comb begin
    do_rewind = (RETX_EN != 0) && rewind;

    // A masked RX push is not a request, so a bus push may proceed instead.
    rx_push  = store_rx_packet_data && !buffer_reserved;
    bus_push = store_tx_data && !rx_push;
    push_w   = rx_push ? PW'(1) : bus_w_p;
    push_req = rx_push || (bus_push && bus_size_ok);
    push_ok  = push_req && (push_w <= free_space);
    ovf_set  = (bus_push && !bus_size_ok) || (push_req && !push_ok);

    // A rewind discards same-cycle pops entirely, including their errors.
    tx_pop  = get_tx_packet_data && !do_rewind;
    bus_pop = get_rx_data && !get_tx_packet_data && !do_rewind;
    pop_w   = tx_pop ? PW'(1) : bus_w_p;
    pop_req = tx_pop || (bus_pop && bus_size_ok);
    pop_ok  = pop_req && (pop_w <= occ);
    unf_set = (bus_pop && !bus_size_ok) || (pop_req && !pop_ok);
  end

  // ---------------------------------------------------------------------------
  // Next pointers
  // ---------------------------------------------------------------------------
  always_comb begin
    wp_next = push_ok ? (wp + push_w) : wp;

    if (do_rewind)   rp_next = mk;
    else if (pop_ok) rp_next = rp + pop_w;
    else             rp_next = rp;

    // The mark takes the read pointer after this cycle's pop.
    if (RETX_EN == 0)   mk_next = rp_next;
    else if (do_rewind) mk_next = mk;
    else if (mark_set)  mk_next = rp_next;
    else                mk_next = mk;
  end

  // ---------------------------------------------------------------------------
  // Read word assembly: lowest-index byte first, unused upper bytes zero.
  // ---------------------------------------------------------------------------
  logic [8*BUS_BYTES-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      if (PW'(i) < pop_w) rd_word[8*i +: 8] = mem[addr_at(rp, i)];
    end
  end

  // ---------------------------------------------------------------------------
  // Storage (not reset; contents are only meaningful between rp and wp)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (n_rst && !clear && push_ok) begin
      for (int i = 0; i < BUS_BYTES; i++) begin
        if (PW'(i) < push_w)
          mem[addr_at(wp, i)] <= rx_push ? rx_packet_data : tx_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, registered outputs and sticky errors
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wp             <= '0;
      rp             <= '0;
      mk             <= '0;
      rx_data        <= '0;
      tx_packet_data <= '0;
      overflow_err   <= 1'b0;
      underflow_err  <= 1'b0;
    end else if (clear) begin
      wp             <= '0;
      rp             <= '0;
      mk             <= '0;
      rx_data        <= '0;
      tx_packet_data <= '0;
      overflow_err   <= 1'b0;
      underflow_err  <= 1'b0;
    end else begin
      wp <= wp_next;
      rp <= rp_next;
      mk <= mk_next;
      if (pop_ok && tx_pop)  tx_packet_data <= rd_word[7:0];
      if (pop_ok && !tx_pop) rx_data        <= rd_word;
      if (ovf_set) overflow_err  <= 1'b1;
      if (unf_set) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_data_buffer.sv
// -----------------------------------------------------------------------------
// tb_param_data_buffer
//
// Bench for param_data_buffer (DEPTH=64, BUS_BYTES=4, RETX_EN=1). A byte-queue
// model (readable bytes plus the popped-but-unmarked retransmit bytes) tracks
// the expected buffer contents; popped words are queued in exp_q as stimulus
// is driven and compared once the DUT output has loaded.
// -----------------------------------------------------------------------------
module tb_param_data_buffer;

  localparam int DEPTH     = 64;
  localparam int BUS_BYTES = 4;
  localparam int AW        = 6;
  localparam int SW        = 2;
  localparam int W         = 8 * BUS_BYTES;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          n_rst;
  logic          clear, store_rx_packet_data, get_rx_data, store_tx_data;
  logic          get_tx_packet_data, buffer_reserved, mark_set, rewind;
  logic [7:0]    rx_packet_data;
  logic [SW-1:0] data_size;
  logic [W-1:0]  tx_data;
  logic [AW:0]   buffer_occupancy;
  logic [W-1:0]  rx_data;
  logic [7:0]    tx_packet_data;
  logic          full, empty, overflow_err, underflow_err;

  always #5 clk = ~clk;

  param_data_buffer #(.DEPTH(DEPTH), .BUS_BYTES(BUS_BYTES), .RETX_EN(1)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_rx_data          (get_rx_data),
    .data_size            (data_size),
    .tx_data              (tx_data),
    .store_tx_data        (store_tx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .buffer_reserved      (buffer_reserved),
    .mark_set             (mark_set),
    .rewind               (rewind),
    .buffer_occupancy     (buffer_occupancy),
    .rx_data              (rx_data),
    .tx_packet_data       (tx_packet_data),
    .full                 (full),
    .empty                (empty),
    .overflow_err         (overflow_err),
    .underflow_err        (underflow_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and model state
  // ---------------------------------------------------------------------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   mq[$];     // readable bytes, oldest first
  logic [7:0]   hist[$];   // popped bytes still protected by the mark
  logic [W-1:0] exp_rx;
  logic [7:0]   exp_tx;
  logic         exp_ovf, exp_unf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_req();
    clear                = 1'b0;
    store_rx_packet_data = 1'b0;
    get_rx_data          = 1'b0;
    store_tx_data        = 1'b0;
    get_tx_packet_data   = 1'b0;
    buffer_reserved      = 1'b0;
    mark_set             = 1'b0;
    rewind               = 1'b0;
    rx_packet_data       = '0;
    data_size            = '0;
    tx_data              = '0;
  endtask

  task automatic model_clear();
    mq.delete();
    hist.delete();
    exp_q.delete();
    exp_rx  = '0;
    exp_tx  = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic check_status();
    check("occupancy", buffer_occupancy, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, (DEPTH - mq.size() - hist.size()) == 0);
    check("overflow_err", overflow_err, exp_ovf);
    check("underflow_err", underflow_err, exp_unf);
    check("rx_data_hold", rx_data, exp_rx);
    check("tx_data_hold", tx_packet_data, exp_tx);
  endtask

  // Apply the currently driven requests to the model, clock one edge, compare.
  task automatic step();
    int           occ, free, pw, uw;
    logic         rxp, popped;
    logic [W-1:0] v;
    popped = 1'b0;
    if (clear) begin
      model_clear();
    end else begin
      occ  = mq.size();
      free = DEPTH - mq.size() - hist.size();
      rxp  = store_rx_packet_data && !buffer_reserved;
      pw   = rxp ? 1 : (store_tx_data ? int'(data_size) + 1 : 0);
      uw   = get_tx_packet_data ? 1 : (get_rx_data ? int'(data_size) + 1 : 0);
      if (rewind) begin
        mq = {hist, mq};
        hist.delete();
      end else if (uw > 0) begin
        if (uw <= occ) begin
          v = '0;
          for (int i = 0; i < uw; i++) begin
            v[8*i +: 8] = mq[0];
            hist.push_back(mq.pop_front());
          end
          exp_q.push_back(v);
          popped = 1'b1;
          if (get_tx_packet_data) exp_tx = v[7:0];
          else                    exp_rx = v;
        end else begin
          exp_unf = 1'b1;
        end
      end
      if (!rewind && mark_set) hist.delete();
      if (pw > 0) begin
        if (pw <= free) begin
          for (int i = 0; i < pw; i++)
            mq.push_back(rxp ? rx_packet_data : tx_data[8*i +: 8]);
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (popped) begin
      if (get_tx_packet_data) check("tx_pop", tx_packet_data, exp_q.pop_front());
      else                    check("bus_pop", rx_data, exp_q.pop_front());
    end
    check_status();
    idle_req();
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic push_rx(input logic [7:0] b);
    store_rx_packet_data = 1'b1;
    rx_packet_data       = b;
    step();
  endtask

  task automatic bus_wr(input logic [SW-1:0] sz, input logic [W-1:0] d);
    store_tx_data = 1'b1;
    data_size     = sz;
    tx_data       = d;
    step();
  endtask

  task automatic bus_rd(input logic [SW-1:0] sz);
    get_rx_data = 1'b1;
    data_size   = sz;
    step();
  endtask

  task automatic tx_pop();
    get_tx_packet_data = 1'b1;
    step();
  endtask

  task automatic do_mark();
    mark_set = 1'b1;
    step();
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle_req();
    model_clear();
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_status();
    @(negedge clk);
    n_rst = 1'b1;

    // Four RX bytes read back as one bus word.
    push_rx(8'hFF); push_rx(8'hC9); push_rx(8'h9A); push_rx(8'h3B);
    check("plan_occ4", buffer_occupancy, 4);
    bus_rd(2'd3);
    check("plan_word", rx_data, 32'h3B9AC9FF);
    check("plan_empty", empty, 1);

    // Two-byte bus write drained by TX pops.
    bus_wr(2'd1, 32'h0000_2B67);
    tx_pop();
    check("plan_tx0", tx_packet_data, 8'h67);
    tx_pop();
    check("plan_tx1", tx_packet_data, 8'h2B);
    do_mark();

    // Fill to full, overflow, drain, underflow.
    for (int i = 0; i < DEPTH; i++) push_rx(8'($urandom_range(0, 255)));
    check("plan_full", full, 1);
    check("plan_occ64", buffer_occupancy, 64);
    bus_wr(2'd0, 32'h0000_00AA);
    check("plan_ovf", overflow_err, 1);
    for (int i = 0; i < DEPTH / 4; i++) bus_rd(2'd3);
    do_mark();
    tx_pop();
    check("plan_unf", underflow_err, 1);

    // Wrap-around across address 63 -> 0.
    do_clear();
    for (int i = 0; i < 15; i++) bus_wr(2'd3, $urandom());
    bus_wr(2'd1, $urandom());
    for (int i = 0; i < 15; i++) bus_rd(2'd3);
    bus_rd(2'd1);
    do_mark();
    bus_wr(2'd3, 32'hDEADBEEF);
    bus_rd(2'd3);
    check("plan_wrap", rx_data, 32'hDEADBEEF);
    bus_rd(2'd0);
    check("plan_wrap_unf", underflow_err, 1);

    // Retransmit: pop 8, rewind, re-read the same 8.
    do_clear();
    bus_wr(2'd3, 32'h44332211);
    bus_wr(2'd3, 32'h88776655);
    for (int i = 0; i < 8; i++) tx_pop();
    do_rewind();
    check("plan_rewind_occ", buffer_occupancy, 8);
    for (int i = 0; i < 8; i++) begin
      tx_pop();
      check("plan_retx_byte", tx_packet_data, 8'(8'h11 * (i + 1)));
    end
    for (int i = 0; i < 57; i++) push_rx(8'(i));
    check("plan_protect_ovf", overflow_err, 1);
    check("plan_protect_occ", buffer_occupancy, 56);
    do_mark();
    for (int i = 0; i < 8; i++) push_rx(8'(i + 100));
    check("plan_mark_full", full, 1);

    // Arbitration: RX push beats bus push, TX pop beats bus pop, reserved RX.
    do_clear();
    store_rx_packet_data = 1'b1; rx_packet_data = 8'hA5;
    store_tx_data = 1'b1; data_size = 2'd3; tx_data = 32'h11223344;
    step();
    check("arb_push_occ", buffer_occupancy, 1);
    get_tx_packet_data = 1'b1; get_rx_data = 1'b1; data_size = 2'd3;
    step();
    check("arb_pop_tx", tx_packet_data, 8'hA5);
    check("arb_pop_rx", rx_data, 32'h0);
    buffer_reserved = 1'b1; store_rx_packet_data = 1'b1; rx_packet_data = 8'h77;
    step();
    check("reserved_occ", buffer_occupancy, 0);

    // Clear with same-cycle push and pop mid-packet.
    for (int i = 0; i < 5; i++) push_rx(8'(i + 1));
    tx_pop();
    clear = 1'b1; store_rx_packet_data = 1'b1; rx_packet_data = 8'hEE;
    get_tx_packet_data = 1'b1;
    step();
    check("clear_occ", buffer_occupancy, 0);
    check("clear_tx", tx_packet_data, 8'h00);
    push_rx(8'h5A);
    tx_pop();
    check("clear_after", tx_packet_data, 8'h5A);

    // Randomised mix of all requests.
    for (int n = 0; n < 400; n++) begin
      store_rx_packet_data = ($urandom_range(0, 3) == 0);
      rx_packet_data       = 8'($urandom_range(0, 255));
      store_tx_data        = ($urandom_range(0, 3) == 0);
      data_size            = SW'($urandom_range(0, 3));
      tx_data              = $urandom();
      get_rx_data          = ($urandom_range(0, 3) == 0);
      get_tx_packet_data   = ($urandom_range(0, 4) == 0);
      mark_set             = ($urandom_range(0, 7) == 0);
      rewind               = ($urandom_range(0, 15) == 0);
      buffer_reserved      = ($urandom_range(0, 7) == 0);
      clear                = ($urandom_range(0, 63) == 0);
      step();
    end

    // Asynchronous reset in the middle of a transfer.
    push_rx(8'h31); push_rx(8'h32); bus_rd(2'd1);
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h33;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    model_clear();
    check_status();
    idle_req();
    @(negedge clk);
    n_rst = 1'b1;
    push_rx(8'h44);
    tx_pop();
    check("post_reset_tx", tx_packet_data, 8'h44);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_data_buffer.md
# param_data_buffer

Parametrised successor to the USB endpoint data buffer. It is a circular byte FIFO between the USB packet side (byte-wide RX store, TX fetch) and the AHB-Lite slave side (multi-byte bus read/write). It adds configurable depth and bus width, full/empty flags, sticky overflow/underflow errors, and a mark/rewind mechanism so a TX packet can be retransmitted after a NAK or timeout without the host rewriting it. Instantiated in the USB device top between the RX/TX packet engines and the AHB-Lite slave.

## Interface
- DEPTH, 64, buffer size in bytes; power of 2, ≥4, ≥BUS_BYTES
- BUS_BYTES, 4, bus port width in bytes; power of 2, 1..8
- RETX_EN, 1, 1 = explicit mark/rewind; 0 = mark tracks read pointer every cycle, rewind ignored
- Derived: AW = log2(DEPTH); SW = max(1, log2(BUS_BYTES))

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush
- store_rx_packet_data  in  1  push one byte from USB RX
- rx_packet_data  in  8  RX byte
- get_rx_data  in  1  pop data_size+1 bytes to the bus
- data_size  in  SW  bytes-minus-one for bus transfers
- tx_data  in  8*BUS_BYTES  bus write data, byte 0 = bits [7:0]
- store_tx_data  in  1  push data_size+1 bytes from the bus
- get_tx_packet_data  in  1  pop one byte to USB TX
- buffer_reserved  in  1  buffer owned by the TX path; RX pushes are ignored
- mark_set  in  1  mark := read pointer (release retransmit region)
- rewind  in  1  read pointer := mark
- buffer_occupancy  out  AW+1  bytes readable
- rx_data  out  8*BUS_BYTES  registered bus read data
- tx_packet_data  out  8  registered TX byte
- full, empty  out  1  occupancy flags
- overflow_err, underflow_err  out  1  sticky error flags

## Operation
- Storage: DEPTH×8 array, with write pointer wp, read pointer rp and mark mk, each AW+1 bits wrapping modulo 2^(AW+1). Address = ptr[AW-1:0].
- occupancy = wp − rp. Free space = DEPTH − (wp − mk). Bytes between mk and rp are protected and cannot be overwritten.
- Push width: 1 for store_rx_packet_data, data_size+1 for store_tx_data. Pop width: data_size+1 for get_rx_data, 1 for get_tx_packet_data.
- Byte order: the lowest-index byte is first in and first out. A partial bus read zero-fills the upper bytes of rx_data.
- data_size+1 > BUS_BYTES: the request is ignored and overflow_err (write) or underflow_err (read) is set.
- At most one push source and one pop source are honoured per cycle:
  - RX push wins over bus push.
  - TX pop wins over bus pop.
  - The losing request is dropped and does not set an error.
- Push legality is checked against the pre-edge free space. Pop legality is checked against the pre-edge occupancy. A simultaneous push and pop are both legal only on those pre-edge values.
- Illegal push: no byte is written, wp is unchanged, overflow_err := 1.
- Illegal pop: rp and the data output are unchanged, underflow_err := 1.
- store_rx_packet_data while buffer_reserved = 1 is ignored, with no error.
- Priority per edge: clear > rewind > mark_set > push/pop.
  - clear: wp = rp = mk = 0, data outputs and errors zeroed, same-cycle push/pop discarded.
  - rewind (RETX_EN = 1): rp := mk; same-cycle pops discarded, same-cycle pushes honoured.
  - mark_set: mk := rp after this cycle's pop.
- RETX_EN = 0: mk := next rp every cycle, so free space = DEPTH − occupancy.
- full = (free space == 0). empty = (occupancy == 0). Both are combinational from registered pointers.

## Timing
- Reset (async assert, sync release by the system): wp, rp, mk, rx_data, tx_packet_data, overflow_err, underflow_err = 0; buffer_occupancy = 0; empty = 1; full = 0.
- Requests are sampled on the rising edge. Pointers and occupancy update on that edge.
- rx_data and tx_packet_data load on the same edge as a legal pop and are valid from that edge (one-cycle latency). They hold until the next legal pop or clear.
- Written bytes are poppable on the cycle after the write edge. Pop and push on the same cycle with occupancy 0 is an underflow.
- Level-held requests act every cycle: the requester pulses for exactly one cycle per transfer.
- Wrap-around is seamless. A multi-byte transfer crossing address DEPTH−1→0 splits across the boundary with correct byte order.

## Test plan
- Reset, push 4 RX bytes 0xFF,0xC9,0x9A,0x3B, get_rx_data size 3 -> rx_data = 0x3B9AC9FF one edge later; occupancy 4→0; empty = 1.
- Bus write size 1 data 0x2B67, two TX pops -> tx_packet_data 0x67 then 0x2B; occupancy 2→1→0.
- DEPTH = 64: push 64 bytes -> full = 1, occupancy 64. A further bus write size 0 -> overflow_err = 1, occupancy stays 64. An empty-buffer pop -> underflow_err = 1.
- Wrap: advance pointers to 62, bus write size 3 of 0xDEADBEEF, bus read size 3 -> 0xDEADBEEF; the size-0 read that follows is underflow.
- RETX_EN = 1: write 8 bytes, pop 8, rewind -> occupancy 8 and the same 8 bytes are re-read. Then mark_set with free space 64 restored; writing 57 bytes before mark_set -> overflow.
- Simultaneous clear + push + pop mid-packet -> all pointers 0, outputs 0, nothing stored; asynchronous n_rst mid-transfer -> reset values immediately.
